dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and access sequencer for the single-ported data memory (`dmem`). It serves the CPU load/store unit (port 0) and a secondary master such as a debug loader or DMA (port 1). Each port uses a req/gnt/rvalid handshake. The block latches one command at a time, drives `dmem` through a fixed access sequence that accounts for its clocked read, and returns sign- or zero-extended read data to the owning port.

## Interface
Parameters:
- `ADDR_W`, default 32: address width; only `[16:0]` is meaningful to `dmem`.
- `DATA_W`, default 32: data width; fixed at 32 in this design.

Ports (`x` is 0 or 1):
- `clk`, in, 1: single clock. It also drives the `dmem` `rdclk`/`wrclk` pins.
- `rst`, in, 1: asynchronous, active-high reset.
- `mx_req`, in, 1: request from port x.
- `mx_addr`, in, ADDR_W: byte address.
- `mx_wdata`, in, DATA_W: store data, right-aligned.
- `mx_memop`, in, 3: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- `mx_we`, in, 1: 1 means store, 0 means load.
- `mx_gnt`, out, 1: one-cycle pulse; the command has been accepted.
- `mx_rvalid`, out, 1: one-cycle pulse; `mx_rdata` is valid.
- `mx_rdata`, out, DATA_W: load result, captured from `dmem` `dataout`.
- `mem_addr`, out, ADDR_W: drives `dmem` `addr`.
- `mem_datain`, out, DATA_W: drives `dmem` `datain`.
- `mem_memop`, out, 3: drives `dmem` `memop`.
- `mem_we`, out, 1: drives `dmem` `we`.
- `mem_dataout`, in, DATA_W: from `dmem` `dataout`; already extended per `memop`.

## Operation
- FSM has three states: IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE:**
  - If no `req` is high, the FSM stays in IDLE.
  - If one `req` is high, that port wins.
  - If both are high, the port not equal to `last` wins. `last` resets to 1, so port 0 wins the first tie.
  - At the accept edge, these are registered: `cmd_addr`, `cmd_wdata`, `cmd_memop`, `cmd_we`, `owner`. `last` is set to `owner`.
  - Next state is ACCESS.
- **ACCESS:**
  - `m[owner]_gnt` = 1.
  - `mem_*` are driven from the `cmd_*` registers.
  - `mem_we` = `cmd_we`.
  - Store: next state is IDLE. The write commits at the clock edge ending ACCESS.
  - Load: next state is RESP.
- **RESP:**
  - `mem_addr` and `mem_memop` are held, and `mem_we` = 0.
  - `mem_dataout` is registered into `m[owner]_rdata`.
  - `m[owner]_rvalid` = 1 in the following cycle, which is an IDLE cycle.
- **Outside ACCESS/RESP:**
  - `mem_we` = 0.
  - `mem_addr`, `mem_datain` and `mem_memop` hold their last values; they are 0 after reset.
- **Requester rules:**
  - A requester holds `req` and its command signals stable until it sees `gnt`.
  - Signal changes after acceptance are ignored.
  - A `req` still high in the IDLE cycle after a transaction counts as a new request.
- **Illegal memop:**
  - A store with `memop` ∉ {000, 001, 010} completes normally with `gnt` but writes no bytes, because the byte mask is 0.
  - A load with an undefined `memop` returns the full word.
- `rdata` of the non-owning port holds its previous value.

## Timing
- **Reset values:**
  - All `gnt` and `rvalid` outputs: 0.
  - All `rdata` outputs: 0.
  - All `mem_*` outputs: 0.
  - `last` = 1.
  - FSM in IDLE.
- **Mid-transaction reset:** asserting `rst` during a transaction drops it immediately. No `gnt` or `rvalid` follows, and any in-flight write is abandoned if `rst` arrives before its commit edge.
- **Load latency:** `req` sampled at edge k → `gnt` in cycle k+1 → RESP in k+2 → `rvalid`/`rdata` in k+3. A load occupies the memory for 3 cycles.
- **Store latency:** `req` at edge k → `gnt` in cycle k+1, and the data is in memory after edge k+2. A store occupies the memory for 2 cycles.
- **Back-to-back:** a new request can be accepted in the same IDLE cycle that `rvalid` is asserted for the previous load.
- **Contention:** with both ports requesting continuously, grants alternate 0, 1, 0, 1, …, so no port waits more than one transaction.

## Structure
- Package `dmem_arb_pkg` contains:
  - The state enum (IDLE, ACCESS, RESP).
  - The memop localparams: `MEMOP_LB`=000, `MEMOP_LH`=001, `MEMOP_LW`=010, `MEMOP_LBU`=100, `MEMOP_LHU`=101.
- Sub-module `rr_arb2` is the combinational two-request round-robin picker.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `valid`, `sel`.
- The FSM, command registers and the `dmem` instance connection stay in the top module.

## Test plan
- **Reset:** `rst` pulse → all outputs 0. Then port 0 stores word 0xDEADBEEF at 0x100, then loads from 0x100 → `m0_rvalid` in cycle k+3 with `m0_rdata` = 0xDEADBEEF.
- **Byte and half stores:**
  - Write 0x11223344 to 0x200.
  - Byte store (memop=000) of 0xAA to 0x201.
  - Load at 0x200 with memop 010 → 0x1122AA44.
  - Load at 0x201 with memop 000 → 0xFFFFFFAA; with memop 100 → 0x000000AA.
- **Tie arbitration:** both ports issue a load in the same cycle, both held high → port 0 granted first, then port 1. Repeated continuously → grants alternate 0, 1, 0, 1 over 8 transactions, with no `gnt` given to an idle port.
- **Mid-transaction reset:** port 1 store of 0x55 to 0x300, with `rst` asserted during ACCESS before the commit edge → no `m1_gnt` seen after reset, a load of 0x300 returns its pre-test value, and the FSM is back in IDLE.
- **Back-to-back loads:** port 0 issues a new request in the IDLE cycle where `m0_rvalid` is high → it is accepted in that cycle. The second load's `rvalid` arrives exactly 3 cycles after the first.
- **Illegal store memop:** store with memop=011 → `gnt` pulses and no bytes change at the target address.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and memop encodings for the dmem arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_LW  = 3'b010;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker: on a tie the port that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       sel
);

  always_comb begin
    valid = |req;
    sel   = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the single-ported, clocked-read data memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [2:0]        m0_memop,
  input  logic              m0_we,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [2:0]        m1_memop,
  input  logic              m1_we,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  output logic [2:0]        mem_memop,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dataout
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [2:0]        cmd_memop;
  logic              cmd_we;
  logic              owner;
  logic              last;
  logic              arb_valid;
  logic              arb_sel;

  rr_arb2 u_arb (
    .req   ({m1_req, m0_req}),
    .last  (last),
    .valid (arb_valid),
    .sel   (arb_sel)
  );

  // Command registers only load at acceptance, so driving the memory straight
  // from them gives "hold last value" outside ACCESS/RESP for free.
  assign mem_addr   = cmd_addr;
  assign mem_datain = cmd_wdata;
  assign mem_memop  = cmd_memop;

  always_comb begin
    state_nx = state;
    m0_gnt   = 1'b0;
    m1_gnt   = 1'b0;
    mem_we   = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_valid) state_nx = ACCESS;
      end
      ACCESS: begin
        m0_gnt   = ~owner;
        m1_gnt   = owner;
        mem_we   = cmd_we;
        state_nx = cmd_we ? IDLE : RESP;
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_memop <= '0;
      cmd_we    <= 1'b0;
      owner     <= 1'b0;
      last      <= 1'b1;
    end else if (state == IDLE && arb_valid) begin
      owner <= arb_sel;
      last  <= arb_sel;
      if (arb_sel) begin
        cmd_addr  <= m1_addr;
        cmd_wdata <= m1_wdata;
        cmd_memop <= m1_memop;
        cmd_we    <= m1_we;
      end else begin
        cmd_addr  <= m0_addr;
        cmd_wdata <= m0_wdata;
        cmd_memop <= m0_memop;
        cmd_we    <= m0_we;
      end
    end
  end

  // The memory's read register is valid during RESP; capture it for the owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= (state == RESP) && !owner;
      m1_rvalid <= (state == RESP) && owner;
      if (state == RESP) begin
        if (owner) m1_rdata <= mem_dataout;
        else       m0_rdata <= mem_dataout;
      end
    end
  end

endmodule
